// File: rtl/kgp_ctrl_pkg.sv
// Shared types and encodings for the KGP-RISC multi-cycle controller.
// Opcodes, condition codes, ALU functions, FSM states and instruction classes.
package kgp_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_IF,
    S_ID,
    S_EX,
    S_MEM,
    S_WB,
    S_HALTED,
    S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    CLS_ALU,
    CLS_ADDI,
    CLS_LW,
    CLS_SW,
    CLS_BEQZ,
    CLS_BNEZ,
    CLS_J,
    CLS_HALT,
    CLS_ILL
  } iclass_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h01;
  localparam logic [5:0] OP_LW    = 6'h02;
  localparam logic [5:0] OP_SW    = 6'h03;
  localparam logic [5:0] OP_BEQZ  = 6'h04;
  localparam logic [5:0] OP_BNEZ  = 6'h05;
  localparam logic [5:0] OP_J     = 6'h06;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [1:0] COND_FALSE  = 2'b00;
  localparam logic [1:0] COND_TRUE   = 2'b01;
  localparam logic [1:0] COND_AZERO  = 2'b10;
  localparam logic [1:0] COND_ANZERO = 2'b11;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;
  localparam logic [3:0] ALU_SRA = 4'd7;

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction decoder: classifies irout and extracts the
// R-type ALU function; anything unrecognised is reported as illegal.
module instr_decode
  import kgp_ctrl_pkg::*;
(
  input  logic [31:0] irout,
  output iclass_t     iclass,
  output logic        illegal,
  output logic [3:0]  alufunc
);

  // Register/immediate/offset fields are consumed by the datapath, not here.
  logic unused_fields;
  assign unused_fields = ^irout[25:6];

  always_comb begin
    iclass  = CLS_ILL;
    alufunc = ALU_ADD;
    case (irout[31:26])
      OP_RTYPE: begin
        if (irout[5:4] == 2'b00) begin
          iclass  = CLS_ALU;
          alufunc = irout[3:0];
        end
      end
      OP_ADDI: iclass = CLS_ADDI;
      OP_LW:   iclass = CLS_LW;
      OP_SW:   iclass = CLS_SW;
      OP_BEQZ: iclass = CLS_BEQZ;
      OP_BNEZ: iclass = CLS_BNEZ;
      OP_J:    iclass = CLS_J;
      OP_HALT: iclass = CLS_HALT;
      default: iclass = CLS_ILL;
    endcase
  end

  assign illegal = (iclass == CLS_ILL);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the KGP-RISC datapath: Moore decode of every
// datapath enable/select from the registered state and irout, plus status and retired count.
module multicycle_ctrl
  import kgp_ctrl_pkg::*;
#(
  parameter int COUNT_W    = 32,
  parameter bit AUTO_START = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [31:0]        irout,
  output logic               readim,
  output logic               ldir,
  output logic               ldnpc,
  output logic               ldA,
  output logic               ldB,
  output logic               ldimm,
  output logic [1:0]         opcond,
  output logic               alusel1,
  output logic               alusel2,
  output logic               aluen,
  output logic               ldaluout,
  output logic [3:0]         alufunc,
  output logic               writedmem,
  output logic               readdmem,
  output logic               ldlmd,
  output logic               selwb,
  output logic               regwrite,
  output logic               branch,
  output logic               ldpc,
  output logic               busy,
  output logic               halted,
  output logic               illegal,
  output logic [COUNT_W-1:0] instr_count
);

  state_t     state, state_nxt;
  iclass_t    iclass;
  logic       dec_illegal;
  logic [3:0] dec_func;
  logic [1:0] br_cond;

  instr_decode u_decode (
    .irout   (irout),
    .iclass  (iclass),
    .illegal (dec_illegal),
    .alufunc (dec_func)
  );

  assign br_cond = (iclass == CLS_BNEZ) ? COND_ANZERO : COND_AZERO;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    readim    = 1'b0;
    ldir      = 1'b0;
    ldnpc     = 1'b0;
    ldA       = 1'b0;
    ldB       = 1'b0;
    ldimm     = 1'b0;
    opcond    = COND_FALSE;
    alusel1   = 1'b0;
    alusel2   = 1'b0;
    aluen     = 1'b0;
    ldaluout  = 1'b0;
    alufunc   = ALU_ADD;
    writedmem = 1'b0;
    readdmem  = 1'b0;
    ldlmd     = 1'b0;
    selwb     = 1'b0;
    regwrite  = 1'b0;
    branch    = 1'b0;
    ldpc      = 1'b0;
    busy      = 1'b0;
    halted    = 1'b0;
    illegal   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start || AUTO_START) state_nxt = S_IF;
      end
      S_IF: begin
        busy      = 1'b1;
        readim    = 1'b1;
        ldir      = 1'b1;
        ldnpc     = 1'b1;
        state_nxt = S_ID;
      end
      // HALT retires here: the PC still steps past it so a restart resumes after it.
      S_ID: begin
        busy  = 1'b1;
        ldA   = 1'b1;
        ldB   = 1'b1;
        ldimm = 1'b1;
        if (dec_illegal) begin
          state_nxt = S_TRAP;
        end else if (iclass == CLS_HALT) begin
          ldpc      = 1'b1;
          state_nxt = S_HALTED;
        end else begin
          state_nxt = S_EX;
        end
      end
      S_EX: begin
        busy     = 1'b1;
        aluen    = 1'b1;
        ldaluout = 1'b1;
        case (iclass)
          CLS_ALU: begin
            alusel1   = 1'b1;
            alufunc   = dec_func;
            state_nxt = S_WB;
          end
          CLS_ADDI: begin
            alusel1   = 1'b1;
            alusel2   = 1'b1;
            state_nxt = S_WB;
          end
          CLS_LW, CLS_SW: begin
            alusel1   = 1'b1;
            alusel2   = 1'b1;
            state_nxt = S_MEM;
          end
          CLS_BEQZ, CLS_BNEZ: begin
            alusel2   = 1'b1;
            opcond    = br_cond;
            state_nxt = S_MEM;
          end
          CLS_J: begin
            branch    = 1'b1;
            ldpc      = 1'b1;
            state_nxt = S_IF;
          end
          default: state_nxt = S_TRAP;
        endcase
      end
      // Branch target (NPC+imm) sits in ALUOut; opcond picks it or NPC.
      S_MEM: begin
        busy = 1'b1;
        case (iclass)
          CLS_LW: begin
            readdmem  = 1'b1;
            ldlmd     = 1'b1;
            state_nxt = S_WB;
          end
          CLS_SW: begin
            writedmem = 1'b1;
            ldpc      = 1'b1;
            state_nxt = S_IF;
          end
          CLS_BEQZ, CLS_BNEZ: begin
            opcond    = br_cond;
            ldpc      = 1'b1;
            state_nxt = S_IF;
          end
          default: state_nxt = S_TRAP;
        endcase
      end
      S_WB: begin
        busy      = 1'b1;
        regwrite  = 1'b1;
        ldpc      = 1'b1;
        selwb     = (iclass != CLS_LW);
        state_nxt = S_IF;
      end
      S_HALTED: begin
        halted = 1'b1;
        if (start) state_nxt = S_IF;
      end
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    instr_count <= '0;
    else if (ldpc) instr_count <= instr_count + COUNT_W'(1);
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed vector table, reset/halt/trap
// sequences, and a random instruction stream checked against a per-instruction model.
module tb_multicycle_ctrl;

  localparam int CW = 8;

  localparam int K_ALU  = 0;
  localparam int K_ADDI = 1;
  localparam int K_LW   = 2;
  localparam int K_SW   = 3;
  localparam int K_BEQZ = 4;
  localparam int K_BNEZ = 5;
  localparam int K_J    = 6;
  localparam int K_HALT = 7;
  localparam int K_ILL  = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [31:0]   irout;
  logic          readim, ldir, ldnpc, ldA, ldB, ldimm;
  logic [1:0]    opcond;
  logic          alusel1, alusel2, aluen, ldaluout;
  logic [3:0]    alufunc;
  logic          writedmem, readdmem, ldlmd, selwb, regwrite, branch, ldpc;
  logic          busy, halted, illegal;
  logic [CW-1:0] instr_count;

  typedef struct packed {
    logic       readim, ldir, ldnpc, ldA, ldB, ldimm;
    logic [1:0] opcond;
    logic       alusel1, alusel2, aluen, ldaluout;
    logic [3:0] alufunc;
    logic       writedmem, readdmem, ldlmd, selwb, regwrite, branch, ldpc;
    logic       busy, halted, illegal;
  } outs_t;

  typedef struct {
    logic [31:0] ir;
    int          cycles;
    logic [3:0]  func;
    logic [1:0]  cond;
    int          regw;
    logic        wbsel;
    logic        halts;
  } vec_t;

  int    checks = 0;
  int    errors = 0;
  int    model_count = 0;
  outs_t exp_q[$];
  vec_t  tbl[10];

  always #5 clk = ~clk;

  multicycle_ctrl #(.COUNT_W(CW), .AUTO_START(1'b0)) dut (
    .clk(clk), .reset(reset), .start(start), .irout(irout),
    .readim(readim), .ldir(ldir), .ldnpc(ldnpc), .ldA(ldA), .ldB(ldB), .ldimm(ldimm),
    .opcond(opcond), .alusel1(alusel1), .alusel2(alusel2), .aluen(aluen),
    .ldaluout(ldaluout), .alufunc(alufunc), .writedmem(writedmem), .readdmem(readdmem),
    .ldlmd(ldlmd), .selwb(selwb), .regwrite(regwrite), .branch(branch), .ldpc(ldpc),
    .busy(busy), .halted(halted), .illegal(illegal), .instr_count(instr_count)
  );

  function automatic outs_t sample();
    outs_t o;
    o.readim = readim;       o.ldir = ldir;         o.ldnpc = ldnpc;
    o.ldA = ldA;             o.ldB = ldB;           o.ldimm = ldimm;
    o.opcond = opcond;       o.alusel1 = alusel1;   o.alusel2 = alusel2;
    o.aluen = aluen;         o.ldaluout = ldaluout; o.alufunc = alufunc;
    o.writedmem = writedmem; o.readdmem = readdmem; o.ldlmd = ldlmd;
    o.selwb = selwb;         o.regwrite = regwrite; o.branch = branch;
    o.ldpc = ldpc;           o.busy = busy;         o.halted = halted;
    o.illegal = illegal;
    return o;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] ir, input logic st);
    irout = ir;
    start = st;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int kind_of(input logic [31:0] ir);
    logic [5:0] op;
    op = ir[31:26];
    case (op)
      6'h00:   return (ir[5:4] == 2'b00) ? K_ALU : K_ILL;
      6'h01:   return K_ADDI;
      6'h02:   return K_LW;
      6'h03:   return K_SW;
      6'h04:   return K_BEQZ;
      6'h05:   return K_BNEZ;
      6'h06:   return K_J;
      6'h3F:   return K_HALT;
      default: return K_ILL;
    endcase
  endfunction

  function automatic logic [31:0] count_mod(input int c);
    return 32'(c % (1 << CW));
  endfunction

  // Expected per-cycle outputs of one instruction, IF first, listed phase by phase.
  task automatic build_expected(input logic [31:0] ir);
    int         k;
    outs_t      o;
    logic [1:0] cond;
    k = kind_of(ir);
    cond = (k == K_BNEZ) ? 2'b11 : 2'b10;
    exp_q.delete();
    o = '0; o.readim = 1; o.ldir = 1; o.ldnpc = 1; o.busy = 1;
    exp_q.push_back(o);
    o = '0; o.ldA = 1; o.ldB = 1; o.ldimm = 1; o.busy = 1; o.ldpc = (k == K_HALT);
    exp_q.push_back(o);
    if (k == K_HALT || k == K_ILL) return;
    o = '0; o.aluen = 1; o.ldaluout = 1; o.busy = 1;
    case (k)
      K_ALU:               begin o.alusel1 = 1; o.alufunc = ir[3:0]; end
      K_ADDI, K_LW, K_SW:  begin o.alusel1 = 1; o.alusel2 = 1; end
      K_BEQZ, K_BNEZ:      begin o.alusel2 = 1; o.opcond = cond; end
      default:             begin o.branch = 1; o.ldpc = 1; end
    endcase
    exp_q.push_back(o);
    if (k == K_J) return;
    if (k == K_LW || k == K_SW || k == K_BEQZ || k == K_BNEZ) begin
      o = '0; o.busy = 1;
      if (k == K_LW)      begin o.readdmem = 1; o.ldlmd = 1; end
      else if (k == K_SW) begin o.writedmem = 1; o.ldpc = 1; end
      else                begin o.opcond = cond; o.ldpc = 1; end
      exp_q.push_back(o);
    end
    if (k == K_ALU || k == K_ADDI || k == K_LW) begin
      o = '0; o.busy = 1; o.regwrite = 1; o.ldpc = 1; o.selwb = (k != K_LW);
      exp_q.push_back(o);
    end
  endtask

  // Entered at the IF sample; leaves at the next IF sample (or in TRAP for illegal).
  task automatic run_instr(input logic [31:0] ir);
    int    k;
    outs_t o;
    k = kind_of(ir);
    build_expected(ir);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) tick();
      checkOutput($sformatf("seq op%02h cyc%0d", ir[31:26], i), 32'(sample()), 32'(exp_q[i]));
      if (i == 0) begin
        checkOutput("count@IF", 32'(instr_count), count_mod(model_count));
        applyStimulus(ir, 1'b0);
      end
    end
    tick();
    if (k != K_ILL) model_count++;
    if (k == K_HALT) begin
      o = '0; o.halted = 1;
      checkOutput("halted idle", 32'(sample()), 32'(o));
      checkOutput("count@halt", 32'(instr_count), count_mod(model_count));
      tick();
      checkOutput("halted hold", 32'(sample()), 32'(o));
      applyStimulus(ir, 1'b1);
      tick();
      start = 1'b0;
    end else if (k == K_ILL) begin
      o = '0; o.illegal = 1;
      checkOutput("trap entry", 32'(sample()), 32'(o));
    end
  endtask

  task automatic trap_test(input logic [31:0] ir);
    outs_t o;
    run_instr(ir);
    o = '0; o.illegal = 1;
    applyStimulus(ir, 1'b1);
    tick();
    checkOutput("trap ignores start", 32'(sample()), 32'(o));
    tick();
    checkOutput("trap hold", 32'(sample()), 32'(o));
    checkOutput("count@trap", 32'(instr_count), count_mod(model_count));
    start = 1'b0;
    reset = 1'b0;
    #1;
    checkOutput("trap reset outs", 32'(sample()), 32'(0));
    model_count = 0;
    tick();
    reset = 1'b1;
    applyStimulus(32'h0, 1'b1);
    tick();
    start = 1'b0;
  endtask

  // Coarse, model-free observation of one instruction: latency, PC loads, EX function.
  task automatic table_run(input int idx, input vec_t v);
    int         n, np, nr, nc, conflicts;
    logic [3:0] f;
    logic [1:0] c;
    logic       sw;
    n = 0; np = 0; nr = 0; nc = 0; conflicts = 0; f = 4'h0; c = 2'b00; sw = 1'b0;
    applyStimulus(v.ir, 1'b0);
    do begin
      if (aluen) f = alufunc;
      if (opcond != 2'b00) begin c = opcond; nc++; end
      if (ldpc) np++;
      if (regwrite) begin nr++; sw = selwb; end
      if ((int'(readdmem) + int'(writedmem) + int'(regwrite)) > 1) conflicts++;
      n++;
      tick();
    end while (!(ldir || halted || illegal) && n < 12);
    checkOutput($sformatf("vec%0d cycles", idx), 32'(n), 32'(v.cycles));
    checkOutput($sformatf("vec%0d ldpc pulses", idx), 32'(np), 32'd1);
    checkOutput($sformatf("vec%0d alufunc", idx), 32'(f), 32'(v.func));
    checkOutput($sformatf("vec%0d opcond", idx), 32'(c), 32'(v.cond));
    checkOutput($sformatf("vec%0d opcond cycles", idx), 32'(nc), (v.cond != 2'b00) ? 32'd2 : 32'd0);
    checkOutput($sformatf("vec%0d regwrite cycles", idx), 32'(nr), 32'(v.regw));
    if (v.regw > 0) checkOutput($sformatf("vec%0d selwb", idx), 32'(sw), 32'(v.wbsel));
    checkOutput($sformatf("vec%0d strobe overlap", idx), 32'(conflicts), 32'd0);
    checkOutput($sformatf("vec%0d halted", idx), 32'(halted), 32'(v.halts));
    model_count++;
    if (halted) begin
      applyStimulus(32'h0, 1'b1);
      tick();
      start = 1'b0;
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ir;
    int          sel;
    ir  = $urandom;
    sel = int'($urandom_range(0, 8));
    case (sel)
      0, 8:    begin ir[31:26] = 6'h00; ir[5:4] = 2'b00; end
      7:       ir[31:26] = 6'h3F;
      default: ir[31:26] = 6'(sel);
    endcase
    return ir;
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tbl[0] = '{32'h0022_1801, 4, 4'd1, 2'b00, 1, 1'b1, 1'b0};
    tbl[1] = '{32'h0000_0002, 4, 4'd2, 2'b00, 1, 1'b1, 1'b0};
    tbl[2] = '{32'h0000_0007, 4, 4'd7, 2'b00, 1, 1'b1, 1'b0};
    tbl[3] = '{32'h0422_0010, 4, 4'd0, 2'b00, 1, 1'b1, 1'b0};
    tbl[4] = '{32'h0800_0004, 5, 4'd0, 2'b00, 1, 1'b0, 1'b0};
    tbl[5] = '{32'h0C00_0008, 4, 4'd0, 2'b00, 0, 1'b0, 1'b0};
    tbl[6] = '{32'h1000_0010, 4, 4'd0, 2'b10, 0, 1'b0, 1'b0};
    tbl[7] = '{32'h1400_0010, 4, 4'd0, 2'b11, 0, 1'b0, 1'b0};
    tbl[8] = '{32'h1800_0100, 3, 4'd0, 2'b00, 0, 1'b0, 1'b0};
    tbl[9] = '{32'hFC00_0000, 2, 4'd0, 2'b00, 0, 1'b0, 1'b1};

    reset = 1'b1;
    applyStimulus(32'h0, 1'b0);
    #3 reset = 1'b0;
    tick();
    tick();
    checkOutput("reset outs", 32'(sample()), 32'(0));
    checkOutput("reset count", 32'(instr_count), 32'd0);
    reset = 1'b1;
    tick();
    checkOutput("idle without start", 32'(sample()), 32'(0));
    applyStimulus(32'h0, 1'b1);
    tick();
    start = 1'b0;
    checkOutput("IF after start", 32'(ldir), 32'd1);

    for (int i = 0; i < 10; i++) table_run(i, tbl[i]);
    checkOutput("count after table", 32'(instr_count), count_mod(model_count));

    // Reset in the middle of an ADD's EX cycle.
    applyStimulus(32'h0000_0000, 1'b0);
    tick();
    tick();
    checkOutput("midEX aluen", 32'(aluen), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("midEX reset outs", 32'(sample()), 32'(0));
    checkOutput("midEX reset count", 32'(instr_count), 32'd0);
    model_count = 0;
    tick();
    reset = 1'b1;
    applyStimulus(32'h0, 1'b1);
    tick();
    start = 1'b0;

    for (int i = 0; i < 300; i++) run_instr(rand_instr());
    checkOutput("count after random", 32'(instr_count), count_mod(model_count));

    trap_test(32'hA800_0000);
    trap_test(32'h0000_0013);
    run_instr(32'h0022_1801);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
